// File: rtl/re_capture.sv
// Receiving end of the camera readout interface: follows the Expose/ADC/NRE/Erase
// sequence, captures two rows from the column ADC bus and streams them out pixel by pixel.
module re_capture #(
    parameter int unsigned DW   = 8,
    parameter int unsigned COLS = 2
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Expose,
    input  logic               Erase,
    input  logic               ADC,
    input  logic               NRE_1,
    input  logic               NRE_2,
    input  logic [COLS*DW-1:0] Pix_data,
    input  logic               Out_ready,
    input  logic               Clear_err,
    output logic [DW-1:0]      Out_data,
    output logic               Out_valid,
    output logic               Out_first,
    output logic               Out_last,
    output logic               Busy,
    output logic [7:0]         Frame_cnt,
    output logic               Overrun,
    output logic               Protocol_err,
    output logic               Frame_err
);

    localparam int unsigned NPix = 2 * COLS;
    localparam int unsigned IdxW = (NPix > 2) ? $clog2(NPix) : 1;
    localparam int unsigned RowW = COLS * DW;

    typedef enum logic [1:0] {StIdle, StExpose, StRead, StStream} state_e;

    state_e              state_q, state_d;
    logic                expose_q, adc_q;
    logic                r1_q, r1_d, r2_q, r2_d;
    logic [2*RowW-1:0]   buf_q, buf_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [7:0]          frame_cnt_q, frame_cnt_d;
    logic                ovr_q, ovr_d, perr_q, perr_d, ferr_q, ferr_d;
    logic                drop_q, drop_d;
    logic                ovr_set, perr_set, ferr_set;
    logic                expose_rise, expose_fall, adc_rise;
    logic                valid, hs, idx_last;
    logic                r1_n, r2_n;
    logic [DW-1:0]       cur_pix;

    assign expose_rise = Expose & ~expose_q;
    assign expose_fall = ~Expose & expose_q;
    assign adc_rise    = ADC & ~adc_q;

    assign valid    = (state_q == StStream);
    assign hs       = valid & Out_ready;
    assign idx_last = (idx_q == IdxW'(NPix - 1));
    assign cur_pix  = buf_q[int'(idx_q) * DW +: DW];

    always_comb begin
        state_d     = state_q;
        r1_d        = r1_q;
        r2_d        = r2_q;
        buf_d       = buf_q;
        idx_d       = idx_q;
        frame_cnt_d = frame_cnt_q;
        drop_d      = drop_q;
        ovr_set     = 1'b0;
        perr_set    = 1'b0;
        ferr_set    = 1'b0;
        r1_n        = r1_q;
        r2_n        = r2_q;

        unique case (state_q)
            StIdle: begin
                if (adc_rise && !drop_q) perr_set = 1'b1;
                if (expose_rise) begin
                    state_d = StExpose;
                    r1_d    = 1'b0;
                    r2_d    = 1'b0;
                    drop_d  = 1'b0;
                end
            end
            StExpose: begin
                if (adc_rise) perr_set = 1'b1;
                if (expose_fall) state_d = StRead;
            end
            StRead: begin
                if (adc_rise) begin
                    if (!NRE_1 && NRE_2 && !r1_q) begin
                        buf_d[0 +: RowW] = Pix_data;
                        r1_n             = 1'b1;
                    end else if (!NRE_2 && NRE_1 && !r2_q) begin
                        buf_d[RowW +: RowW] = Pix_data;
                        r2_n                = 1'b1;
                    end else begin
                        perr_set = 1'b1;
                    end
                end
                r1_d = r1_n;
                r2_d = r2_n;
                // Erase sees the row flags including a capture made on this same edge
                if (Erase) begin
                    if (r1_n && r2_n) begin
                        state_d = StStream;
                        idx_d   = '0;
                    end else begin
                        ferr_set = 1'b1;
                        state_d  = StIdle;
                    end
                end
            end
            StStream: begin
                // A new exposure during streaming is dropped; drop_q mutes its ADC strobes
                if (expose_rise) begin
                    ovr_set = 1'b1;
                    drop_d  = 1'b1;
                end
                if (hs) begin
                    if (idx_last) begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                        state_d     = StIdle;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        ovr_d  = ovr_set  | (ovr_q  & ~Clear_err);
        perr_d = perr_set | (perr_q & ~Clear_err);
        ferr_d = ferr_set | (ferr_q & ~Clear_err);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= StIdle;
            expose_q    <= 1'b0;
            adc_q       <= 1'b0;
            r1_q        <= 1'b0;
            r2_q        <= 1'b0;
            buf_q       <= '0;
            idx_q       <= '0;
            frame_cnt_q <= 8'd0;
            ovr_q       <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            expose_q    <= Expose;
            adc_q       <= ADC;
            r1_q        <= r1_d;
            r2_q        <= r2_d;
            buf_q       <= buf_d;
            idx_q       <= idx_d;
            frame_cnt_q <= frame_cnt_d;
            ovr_q       <= ovr_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            drop_q      <= drop_d;
        end
    end

    always_comb begin
        Out_valid    = valid;
        Out_data     = valid ? cur_pix : '0;
        Out_first    = valid && (idx_q == '0);
        Out_last     = valid && idx_last;
        Busy         = (state_q != StIdle);
        Frame_cnt    = frame_cnt_q;
        Overrun      = ovr_q;
        Protocol_err = perr_q;
        Frame_err    = ferr_q;
    end

endmodule

// File: tb/tb_re_capture.sv
// Directed bench for re_capture: a cycle table for normal/error frames plus
// hand-written sequences for stalls, overrun and mid-stream reset.
module tb_re_capture;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Expose, Erase, ADC, NRE_1, NRE_2;
    logic [15:0] Pix_data;
    logic        Out_ready, Clear_err;
    logic [7:0]  Out_data;
    logic        Out_valid, Out_first, Out_last, Busy;
    logic [7:0]  Frame_cnt;
    logic        Overrun, Protocol_err, Frame_err;

    int total = 0;
    int bad   = 0;

    re_capture #(.DW(8), .COLS(2)) dut (
        .Clk(Clk), .Reset(Reset), .Expose(Expose), .Erase(Erase), .ADC(ADC),
        .NRE_1(NRE_1), .NRE_2(NRE_2), .Pix_data(Pix_data), .Out_ready(Out_ready),
        .Clear_err(Clear_err), .Out_data(Out_data), .Out_valid(Out_valid),
        .Out_first(Out_first), .Out_last(Out_last), .Busy(Busy), .Frame_cnt(Frame_cnt),
        .Overrun(Overrun), .Protocol_err(Protocol_err), .Frame_err(Frame_err)
    );

    always #5 Clk = ~Clk;

    // ctl = {Expose, Erase, ADC, NRE_1, NRE_2}
    // exp = {valid, first, last, busy, data[7:0], frame_cnt[7:0], overrun, proto, frame_err}
    typedef struct {
        logic [4:0]  ctl;
        logic [15:0] pix;
        logic        rdy;
        logic        clr;
        logic [22:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [4:0] ctl, input logic [15:0] pix,
                                input logic rdy, input logic clr, input logic [3:0] eo,
                                input logic [7:0] edata, input logic [7:0] efcnt,
                                input logic [2:0] eflags);
        vec_t v;
        v.ctl = ctl;
        v.pix = pix;
        v.rdy = rdy;
        v.clr = clr;
        v.exp = {eo, edata, efcnt, eflags};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [22:0] outs();
        return {Out_valid, Out_first, Out_last, Busy, Out_data, Frame_cnt,
                Overrun, Protocol_err, Frame_err};
    endfunction

    // Drives a full legal readout; ends one cycle after the Erase edge.
    task automatic readout(input logic [15:0] p1, input logic [15:0] p2);
        Expose = 1'b1; tick(); tick();
        Expose = 1'b0; tick();
        NRE_1 = 1'b0; Pix_data = p1; ADC = 1'b1; tick();
        NRE_1 = 1'b1; ADC = 1'b0; tick();
        NRE_2 = 1'b0; Pix_data = p2; ADC = 1'b1; tick();
        NRE_2 = 1'b1; ADC = 1'b0; Erase = 1'b1; tick();
        Erase = 1'b0;
    endtask

    // Streams one frame; toggle=1 alternates Out_ready starting with 1.
    task automatic stream_check(input logic [15:0] p1, input logic [15:0] p2,
                                input bit toggle, input logic [7:0] exp_cnt);
        logic [7:0] exp_pix [4];
        int n;
        int cyc;
        bool_blk: begin end
        exp_pix[0] = p1[7:0];
        exp_pix[1] = p1[15:8];
        exp_pix[2] = p2[7:0];
        exp_pix[3] = p2[15:8];
        n   = 0;
        cyc = 0;
        while (n < 4 && cyc < 40) begin
            Out_ready = toggle ? ((cyc % 2) == 0) : 1'b1;
            chk("stream_valid", 32'(Out_valid), 32'd1);
            chk($sformatf("pix%0d", n), 32'(Out_data), 32'(exp_pix[n]));
            if (Out_ready) begin
                chk($sformatf("first%0d", n), 32'(Out_first), 32'(n == 0));
                chk($sformatf("last%0d", n), 32'(Out_last), 32'(n == 3));
                n++;
            end
            tick();
            cyc++;
        end
        if (n < 4) chk("stream_timeout", 32'(n), 32'd4);
        chk("end_valid", 32'(Out_valid), 32'd0);
        chk("end_busy", 32'(Busy), 32'd0);
        chk("end_fcnt", 32'(Frame_cnt), 32'(exp_cnt));
        Out_ready = 1'b1;
    endtask

    initial begin
        Reset = 1'b0; Expose = 1'b0; Erase = 1'b0; ADC = 1'b0;
        NRE_1 = 1'b1; NRE_2 = 1'b1; Pix_data = 16'h0; Out_ready = 1'b1; Clear_err = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("reset_outs", 32'(outs()), 32'd0);
        Reset = 1'b1;

        // Normal frame
        vecs.push_back(mk(5'b10011, 16'h0000, 1, 0, 4'b0001, 8'h00, 8'd0, 3'b000));
        vecs.push_back(mk(5'b10011, 16'h0000, 1, 0, 4'b0001, 8'h00, 8'd0, 3'b000));
        vecs.push_back(mk(5'b00011, 16'h0000, 1, 0, 4'b0001, 8'h00, 8'd0, 3'b000));
        vecs.push_back(mk(5'b00001, 16'h1211, 1, 0, 4'b0001, 8'h00, 8'd0, 3'b000));
        vecs.push_back(mk(5'b00101, 16'h1211, 1, 0, 4'b0001, 8'h00, 8'd0, 3'b000));
        vecs.push_back(mk(5'b00011, 16'h0000, 1, 0, 4'b0001, 8'h00, 8'd0, 3'b000));
        vecs.push_back(mk(5'b00110, 16'h2221, 1, 0, 4'b0001, 8'h00, 8'd0, 3'b000));
        vecs.push_back(mk(5'b01011, 16'h0000, 1, 0, 4'b1101, 8'h11, 8'd0, 3'b000));
        vecs.push_back(mk(5'b00011, 16'h0000, 1, 0, 4'b1001, 8'h12, 8'd0, 3'b000));
        vecs.push_back(mk(5'b00011, 16'h0000, 1, 0, 4'b1001, 8'h21, 8'd0, 3'b000));
        vecs.push_back(mk(5'b00011, 16'h0000, 1, 0, 4'b1011, 8'h22, 8'd0, 3'b000));
        vecs.push_back(mk(5'b00011, 16'h0000, 1, 0, 4'b0000, 8'h00, 8'd1, 3'b000));
        // Row 2 missing at Erase
        vecs.push_back(mk(5'b10011, 16'h0000, 1, 0, 4'b0001, 8'h00, 8'd1, 3'b000));
        vecs.push_back(mk(5'b00011, 16'h0000, 1, 0, 4'b0001, 8'h00, 8'd1, 3'b000));
        vecs.push_back(mk(5'b00101, 16'h3433, 1, 0, 4'b0001, 8'h00, 8'd1, 3'b000));
        vecs.push_back(mk(5'b01011, 16'h0000, 1, 0, 4'b0000, 8'h00, 8'd1, 3'b001));
        vecs.push_back(mk(5'b00011, 16'h0000, 1, 0, 4'b0000, 8'h00, 8'd1, 3'b001));
        vecs.push_back(mk(5'b00011, 16'h0000, 1, 1, 4'b0000, 8'h00, 8'd1, 3'b000));
        // Both NRE low on a strobe, then a legal frame; last strobe shares the Erase edge
        vecs.push_back(mk(5'b10011, 16'h0000, 1, 0, 4'b0001, 8'h00, 8'd1, 3'b000));
        vecs.push_back(mk(5'b00011, 16'h0000, 1, 0, 4'b0001, 8'h00, 8'd1, 3'b000));
        vecs.push_back(mk(5'b00100, 16'h5555, 1, 0, 4'b0001, 8'h00, 8'd1, 3'b010));
        vecs.push_back(mk(5'b00100, 16'h5555, 1, 0, 4'b0001, 8'h00, 8'd1, 3'b010));
        vecs.push_back(mk(5'b00011, 16'h0000, 1, 0, 4'b0001, 8'h00, 8'd1, 3'b010));
        vecs.push_back(mk(5'b00101, 16'h4241, 1, 0, 4'b0001, 8'h00, 8'd1, 3'b010));
        vecs.push_back(mk(5'b00011, 16'h0000, 1, 0, 4'b0001, 8'h00, 8'd1, 3'b010));
        vecs.push_back(mk(5'b01110, 16'h4443, 1, 0, 4'b1101, 8'h41, 8'd1, 3'b010));
        vecs.push_back(mk(5'b00011, 16'h0000, 1, 0, 4'b1001, 8'h42, 8'd1, 3'b010));
        vecs.push_back(mk(5'b00011, 16'h0000, 1, 0, 4'b1001, 8'h43, 8'd1, 3'b010));
        vecs.push_back(mk(5'b00011, 16'h0000, 1, 0, 4'b1011, 8'h44, 8'd1, 3'b010));
        vecs.push_back(mk(5'b00011, 16'h0000, 1, 0, 4'b0000, 8'h00, 8'd2, 3'b010));
        vecs.push_back(mk(5'b00011, 16'h0000, 1, 1, 4'b0000, 8'h00, 8'd2, 3'b000));
        // ADC in IDLE; then set and clear on the same edge
        vecs.push_back(mk(5'b00111, 16'h0000, 1, 0, 4'b0000, 8'h00, 8'd2, 3'b010));
        vecs.push_back(mk(5'b00011, 16'h0000, 1, 1, 4'b0000, 8'h00, 8'd2, 3'b000));
        vecs.push_back(mk(5'b00111, 16'h0000, 1, 1, 4'b0000, 8'h00, 8'd2, 3'b010));
        vecs.push_back(mk(5'b00011, 16'h0000, 1, 1, 4'b0000, 8'h00, 8'd2, 3'b000));

        foreach (vecs[i]) begin
            {Expose, Erase, ADC, NRE_1, NRE_2} = vecs[i].ctl;
            Pix_data  = vecs[i].pix;
            Out_ready = vecs[i].rdy;
            Clear_err = vecs[i].clr;
            tick();
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end
        {Expose, Erase, ADC, NRE_1, NRE_2} = 5'b00011;
        Clear_err = 1'b0;

        // Backpressure: ready alternates, data must hold during stalls
        readout(16'h1211, 16'h2221);
        stream_check(16'h1211, 16'h2221, 1'b1, 8'd3);

        // Overrun: second readout while the first frame is stalled
        Out_ready = 1'b0;
        readout(16'h6261, 16'h6463);
        readout(16'h7271, 16'h7473);
        chk("ovr_set", 32'(Overrun), 32'd1);
        chk("ovr_no_perr", 32'(Protocol_err), 32'd0);
        stream_check(16'h6261, 16'h6463, 1'b0, 8'd4);
        chk("ovr_no_perr_end", 32'(Protocol_err), 32'd0);

        // Reset after two pixels streamed
        readout(16'h8281, 16'h8483);
        Out_ready = 1'b1;
        tick();
        tick();
        chk("pre_reset_pix", 32'(Out_data), 32'h83);
        #1 Reset = 1'b0;
        #1;
        chk("async_reset_outs", 32'(outs()), 32'd0);
        tick();
        Reset = 1'b1;
        readout(16'h9291, 16'h9493);
        stream_check(16'h9291, 16'h9493, 1'b0, 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
